ntt_conf_sequencer: RTL and testbench
=====================================

Name: ntt_conf_sequencer

Overview:
- Command-side driver for the mixed-radix butterfly controller. It generates that controller's `conf` state stream and consumes its `done_flag` result.
- Accepts a start/mode request from the host.
- Issues RADIX2 and/or RADIX4 passes for exact operation counts, then holds the DONE state long enough for the enable pipelines to drain.
- Cross-checks `done_flag`, then reports completion or error to the host.

Parameters:
- R2_OPS, 32: cycles conf is held at RADIX2 per radix-2 pass.
- R4_OPS, 96: cycles conf is held at RADIX4 per radix-4 pass (3 stages x 32).
- DRAIN_R2, 9: cycles conf is held at DONE_RADIX2 (flushes the 8-deep write-enable delay).
- DRAIN_R4, 15: cycles conf is held at DONE_RADIX4 (flushes the 14-deep write-enable delay).
- CNT_W, 8: width of the internal cycle counter. Must hold max(R4_OPS, DRAIN_R4).

Ports:
- clk, input, 1: sole clock, rising edge.
- rst, input, 1: asynchronous, active-low reset. Asserted when 0.
- start, input, 1: request pulse, sampled only in IDLE.
- mode, input, 2: 00 = radix-2 only; 01 = radix-4 only; 10 = radix-4 pass then radix-2 pass; 11 = reserved.
- abort, input, 1: synchronous abort, honoured in any state.
- done_flag, input, 2: from the butterfly controller. 01 = radix-2 last op; 10 = radix-4 last op.
- conf, output, 3: to the butterfly controller. IDLE = 000, RADIX2 = 001, RADIX4 = 010, DONE_RADIX2 = 011, DONE_RADIX4 = 100.
- busy, output, 1: high while a job is in progress.
- done, output, 1: one-cycle completion pulse.
- err, output, 1: sticky error flag.

Behaviour:
- Reset (rst = 0, asynchronous): state = IDLE, conf = 000, busy = 0, done = 0, err = 0, counter = 0.
- All outputs are registered. conf changes only on a clk edge.
- States: IDLE, RUN_R4, DRAIN_R4, RUN_R2, DRAIN_R2, FINISH.
- conf per state: IDLE -> 000, RUN_R4 -> 010, DRAIN_R4 -> 100, RUN_R2 -> 001, DRAIN_R2 -> 011, FINISH -> 000.
- busy = 1 in every state except IDLE and FINISH.
- IDLE, start = 1, abort = 0:
  - mode and err are captured; err clears to 0.
  - mode 00 -> RUN_R2; mode 01 or 10 -> RUN_R4; mode 11 -> FINISH with err = 1.
  - start is ignored in every state other than IDLE.
- RUN_x: counter counts 0 .. x_OPS-1. At count x_OPS-1 the next state is DRAIN_x with counter = 0. conf therefore stays at RUN_x for exactly x_OPS cycles.
- done_flag check, first DRAIN_x cycle (counter = 0):
  - Because the controller registers conf, done_flag for the last op is visible in this cycle.
  - DRAIN_R4 requires 10; DRAIN_R2 requires 01. Any other value sets err = 1.
  - The sequence continues regardless of the check result.
  - done_flag is ignored in all other cycles.
- DRAIN_x: lasts DRAIN_x cycles. Next state:
  - DRAIN_R4 with captured mode 10 -> RUN_R2 (counter = 0);
  - otherwise -> FINISH.
- FINISH: done = 1 for exactly one cycle, conf = 000, busy = 0. Next state is IDLE.
- err holds until the next accepted start.
- abort = 1 in any non-IDLE state: next state is IDLE, conf = 000, busy = 0, no done pulse, err unchanged.
- abort = 1 together with start = 1 in IDLE: abort wins and the block stays IDLE.
- Counter never wraps: its width is sized by CNT_W, and the terminal compare uses == with the parameter minus 1.
- Timing, start accepted at edge of cycle 0, mode 00:
  - conf = 001 in cycles 1..32;
  - conf = 011 in cycles 33..41;
  - done pulses in cycle 42.
- Timing, mode 10:
  - conf = 010 in cycles 1..96;
  - conf = 100 in cycles 97..111;
  - conf = 001 in cycles 112..143;
  - conf = 011 in cycles 144..152;
  - done pulses in cycle 153.

Test Plan:
- Reset mid-job: assert rst low during RUN_R4 -> conf, busy, done and err go to 0 immediately, without waiting for a clock edge. After release, the block is IDLE.
- mode 00 start, with the butterfly controller model returning 01 in cycle 33 -> conf = 001 for 32 cycles, then 011 for 9 cycles. done pulses in cycle 42, err = 0.
- mode 10 start -> conf sequence is 010 x96, 100 x15, 001 x32, 011 x9. done pulses in cycle 153. Start pulses issued during the job are ignored.
- mode 01 with the model returning 00 in cycle 97 -> err = 1 in cycle 98 and stays set. done still pulses in cycle 112. The next start clears err.
- abort in cycle 50 of a mode 10 job -> conf = 000 and busy = 0 from cycle 51, no done pulse. A start with abort in the same IDLE cycle is not accepted.
- mode 11 start -> no RUN or DRAIN state, conf stays 000. done and err = 1 in cycle 1.

Source files
------------

// File: rtl/ntt_conf_sequencer_if.sv
// Host and butterfly-controller signals of the conf sequencer.
// slave is the sequencer side; master is the host/controller side.
interface ntt_conf_sequencer_if;
    logic       start;
    logic [1:0] mode;
    logic       abort;
    logic [1:0] done_flag;
    logic [2:0] conf;
    logic       busy;
    logic       done;
    logic       err;

    modport slave (
        input  start, mode, abort, done_flag,
        output conf, busy, done, err
    );

    modport master (
        output start, mode, abort, done_flag,
        input  conf, busy, done, err
    );
endinterface

// File: rtl/ntt_conf_sequencer.sv
// Drives the butterfly controller conf stream for radix-4/radix-2 passes, drains, checks done_flag.
// Outputs registered, one cycle after the state decision; start only sampled in IDLE, abort always wins.
module ntt_conf_sequencer #(
    parameter int R2_OPS   = 32,
    parameter int R4_OPS   = 96,
    parameter int DRAIN_R2 = 9,
    parameter int DRAIN_R4 = 15,
    parameter int CNT_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    ntt_conf_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_RUN_R4, S_DRAIN_R4, S_RUN_R2, S_DRAIN_R2, S_FINISH
    } state_t;

    localparam logic [2:0] CONF_IDLE = 3'b000;
    localparam logic [2:0] CONF_R2   = 3'b001;
    localparam logic [2:0] CONF_R4   = 3'b010;
    localparam logic [2:0] CONF_DR2  = 3'b011;
    localparam logic [2:0] CONF_DR4  = 3'b100;

    localparam logic [CNT_W-1:0] R2_LAST  = CNT_W'(R2_OPS - 1);
    localparam logic [CNT_W-1:0] R4_LAST  = CNT_W'(R4_OPS - 1);
    localparam logic [CNT_W-1:0] DR2_LAST = CNT_W'(DRAIN_R2 - 1);
    localparam logic [CNT_W-1:0] DR4_LAST = CNT_W'(DRAIN_R4 - 1);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [1:0]       mode_q, mode_n;
    logic             err_q, err_n;
    logic [2:0]       conf_q, conf_n;
    logic             busy_q, busy_n;
    logic             done_q, done_n;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            mode_q <= 2'b00;
            err_q  <= 1'b0;
            conf_q <= CONF_IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            mode_q <= mode_n;
            err_q  <= err_n;
            conf_q <= conf_n;
            busy_q <= busy_n;
            done_q <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        mode_n  = mode_q;
        err_n   = err_q;
        unique case (state)
            S_IDLE: begin
                if (bus.start && !bus.abort) begin
                    mode_n = bus.mode;
                    err_n  = 1'b0;
                    cnt_n  = '0;
                    case (bus.mode)
                        2'b00:        state_n = S_RUN_R2;
                        2'b01, 2'b10: state_n = S_RUN_R4;
                        default: begin
                            state_n = S_FINISH;
                            err_n   = 1'b1;
                        end
                    endcase
                end
            end
            S_RUN_R4: begin
                if (cnt == R4_LAST) begin
                    state_n = S_DRAIN_R4;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_DRAIN_R4: begin
                // The controller registers conf, so the last-op flag lines up with the first drain cycle.
                if (cnt == '0 && bus.done_flag != 2'b10) err_n = 1'b1;
                if (cnt == DR4_LAST) begin
                    cnt_n   = '0;
                    state_n = (mode_q == 2'b10) ? S_RUN_R2 : S_FINISH;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_RUN_R2: begin
                if (cnt == R2_LAST) begin
                    state_n = S_DRAIN_R2;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_DRAIN_R2: begin
                if (cnt == '0 && bus.done_flag != 2'b01) err_n = 1'b1;
                if (cnt == DR2_LAST) begin
                    cnt_n   = '0;
                    state_n = S_FINISH;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_FINISH: state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase

        if (bus.abort && state != S_IDLE) begin
            state_n = S_IDLE;
            cnt_n   = '0;
            err_n   = err_q;
        end

        conf_n = CONF_IDLE;
        unique case (state_n)
            S_RUN_R4:   conf_n = CONF_R4;
            S_DRAIN_R4: conf_n = CONF_DR4;
            S_RUN_R2:   conf_n = CONF_R2;
            S_DRAIN_R2: conf_n = CONF_DR2;
            default:    conf_n = CONF_IDLE;
        endcase
        busy_n = (state_n != S_IDLE) && (state_n != S_FINISH);
        done_n = (state_n == S_FINISH);
    end

    assign bus.conf = conf_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.err  = err_q;
endmodule

// File: tb/tb_ntt_conf_sequencer.sv
// Directed bench for ntt_conf_sequencer: per-cycle checks of conf/busy/done/err against hand timelines.
module tb_ntt_conf_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    ntt_conf_sequencer_if bus ();

    ntt_conf_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Start is sampled by the edge that begins cycle 1.
    task automatic start_job(input logic [1:0] m);
        bus.start = 1'b1;
        bus.mode  = m;
        cyc = 0;
        tick();
        bus.start = 1'b0;
    endtask

    function automatic logic [2:0] exp_conf_m10(input int c);
        if (c >= 1 && c <= 96)   return 3'b010;
        if (c >= 97 && c <= 111) return 3'b100;
        if (c >= 112 && c <= 143) return 3'b001;
        if (c >= 144 && c <= 152) return 3'b011;
        return 3'b000;
    endfunction

    initial begin
        bus.start     = 1'b0;
        bus.mode      = 2'b00;
        bus.abort     = 1'b0;
        bus.done_flag = 2'b00;

        // Reset state
        #12;
        chk("rst_conf", 32'(bus.conf), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_err",  32'(bus.err),  32'd0);
        rst = 1'b1;
        tick();
        tick();
        chk("idle_conf", 32'(bus.conf), 32'd0);

        // mode 00: 001 x32, 011 x9, done at 42
        start_job(2'b00);
        while (cyc <= 45) begin
            chk("m00_conf", 32'(bus.conf),
                32'((cyc <= 32) ? 3'b001 : (cyc <= 41) ? 3'b011 : 3'b000));
            chk("m00_busy", 32'(bus.busy), 32'(cyc <= 41));
            chk("m00_done", 32'(bus.done), 32'(cyc == 42));
            bus.done_flag = (cyc == 33) ? 2'b01 : 2'b00;
            tick();
        end
        chk("m00_err", 32'(bus.err), 32'd0);

        // mode 10 with stray starts during the job
        start_job(2'b10);
        while (cyc <= 156) begin
            chk("m10_conf", 32'(bus.conf), 32'(exp_conf_m10(cyc)));
            chk("m10_busy", 32'(bus.busy), 32'(cyc <= 152));
            chk("m10_done", 32'(bus.done), 32'(cyc == 153));
            bus.done_flag = (cyc == 97) ? 2'b10 : (cyc == 144) ? 2'b01 : 2'b00;
            bus.start = (cyc == 10 || cyc == 100 || cyc == 120);
            bus.mode  = 2'b00;
            tick();
        end
        bus.start = 1'b0;
        chk("m10_err", 32'(bus.err), 32'd0);
        chk("m10_idle_conf", 32'(bus.conf), 32'd0);

        // mode 01 with a bad done_flag: err from cycle 98, done still at 112
        bus.done_flag = 2'b00;
        start_job(2'b01);
        while (cyc <= 115) begin
            chk("m01_conf", 32'(bus.conf),
                32'((cyc <= 96) ? 3'b010 : (cyc <= 111) ? 3'b100 : 3'b000));
            chk("m01_busy", 32'(bus.busy), 32'(cyc <= 111));
            chk("m01_done", 32'(bus.done), 32'(cyc == 112));
            chk("m01_err",  32'(bus.err),  32'(cyc >= 98));
            tick();
        end

        // New start clears err; abort during cycle 50 of a mode 10 job
        start_job(2'b10);
        chk("clr_err", 32'(bus.err), 32'd0);
        while (cyc <= 60) begin
            chk("abt_conf", 32'(bus.conf), 32'((cyc <= 50) ? 3'b010 : 3'b000));
            chk("abt_busy", 32'(bus.busy), 32'(cyc <= 50));
            chk("abt_done", 32'(bus.done), 32'd0);
            bus.abort = (cyc == 50);
            tick();
        end
        chk("abt_err", 32'(bus.err), 32'd0);

        // Abort together with start in IDLE: not accepted
        bus.start = 1'b1;
        bus.abort = 1'b1;
        bus.mode  = 2'b00;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk("abtst_busy", 32'(bus.busy), 32'd0);
        chk("abtst_conf", 32'(bus.conf), 32'd0);
        tick();
        chk("abtst_busy2", 32'(bus.busy), 32'd0);
        chk("abtst_done2", 32'(bus.done), 32'd0);

        // mode 11: straight to FINISH with err
        start_job(2'b11);
        chk("m11_done", 32'(bus.done), 32'd1);
        chk("m11_err",  32'(bus.err),  32'd1);
        chk("m11_conf", 32'(bus.conf), 32'd0);
        chk("m11_busy", 32'(bus.busy), 32'd0);
        tick();
        chk("m11_done2", 32'(bus.done), 32'd0);
        chk("m11_err2",  32'(bus.err),  32'd1);
        chk("m11_conf2", 32'(bus.conf), 32'd0);

        // Asynchronous reset in the middle of a radix-4 pass
        start_job(2'b01);
        while (cyc < 20) tick();
        chk("mid_conf", 32'(bus.conf), 32'd2);
        chk("mid_busy", 32'(bus.busy), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_conf", 32'(bus.conf), 32'd0);
        chk("arst_busy", 32'(bus.busy), 32'd0);
        chk("arst_done", 32'(bus.done), 32'd0);
        chk("arst_err",  32'(bus.err),  32'd0);
        #2;
        rst = 1'b1;
        tick();
        tick();
        chk("post_conf", 32'(bus.conf), 32'd0);
        chk("post_busy", 32'(bus.busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
